column_move_collector: RTL and testbench

Parametrised collection stage between a column of cell units and the move-ordering control. It replaces a column's loose per-cell move outputs with one buffered stream. Each cycle it arbitrates among per-row candidate moves, using MVV-LVA priority or round-robin. It pushes the winner into a FIFO and presents moves to control over a valid/ready handshake. It also reports when the column has finished generating moves for the current board.

---
 rtl/column_move_collector.sv | 140 ++++++++++++++
 tb/tb_column_move_collector.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/column_move_collector.sv
// column_move_collector: gathers per-row candidate moves from a column of cell
// units into one buffered stream for move-ordering control. Each cycle one row
// wins arbitration (MVV-LVA when SORT=1, round-robin when SORT=0) and its move
// is pushed, with its score, into a circular FIFO.
// Latency: an accepted move reaches m_valid/m_move one edge later when the FIFO
// is empty. Backpressure: when the FIFO is full all cell_ready bits stay low,
// even if m_ready is high in the same cycle.
// Ports:
//   clk, rst (async, active high); newboard: synchronous flush for a new board.
//   cell_valid/cell_move/cell_done in, cell_ready out: per-row offer, move,
//   exhaustion level and one-hot accept.
//   m_valid/m_move/m_score out, m_ready in: head of FIFO handshake.
//   level: FIFO occupancy. col_done: sticky "column exhausted" flag.
module column_move_collector #(
  parameter int ROWS  = 8,
  parameter int DEPTH = 16,
  parameter int SORT  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       newboard,
  input  logic [ROWS-1:0]            cell_valid,
  input  logic [ROWS*18-1:0]         cell_move,
  input  logic [ROWS-1:0]            cell_done,
  output logic [ROWS-1:0]            cell_ready,
  output logic                       m_valid,
  output logic [17:0]                m_move,
  output logic [5:0]                 m_score,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       col_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int RW = $clog2(ROWS);

  // Code 7 is reserved and behaves like an empty square.
  function automatic logic [2:0] piece(input logic [2:0] code);
    return (code == 3'd7) ? 3'd0 : code;
  endfunction

  logic [5:0]    score [ROWS];
  logic [ROWS-1:0] grant;
  logic [RW-1:0] win;
  logic [RW-1:0] rr;
  logic          found;
  logic [5:0]    best;
  int            idx;

  logic [AW-1:0] wr;
  logic [AW-1:0] rd;
  logic [23:0]   mem [DEPTH];
  logic [23:0]   head;
  logic [17:0]   win_move;
  logic          full;
  logic          push;
  logic          pop;

  // Score = {victim, 7 - attacker}: most valuable victim first, cheapest
  // attacker breaks ties.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      score[i] = {piece(cell_move[18*i +: 3]), 3'd7 - piece(cell_move[18*i+3 +: 3])};
    end
  end

  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    best  = '0;
    idx   = 0;
    if (SORT != 0) begin
      // Strict '>' while scanning upward keeps the lowest row on ties.
      for (int i = 0; i < ROWS; i++) begin
        if (cell_valid[i] && (!found || score[i] > best)) begin
          found = 1'b1;
          best  = score[i];
          win   = i[RW-1:0];
        end
      end
    end else begin
      for (int k = 0; k < ROWS; k++) begin
        idx = int'(rr) + k;
        if (idx >= ROWS) idx = idx - ROWS;
        if (!found && cell_valid[idx]) begin
          found = 1'b1;
          win   = idx[RW-1:0];
        end
      end
    end
    if (found) grant[win] = 1'b1;
  end

  // Full looks only at the registered level, so a same-cycle pop never frees
  // a slot early.
  assign full       = (level == LW'(DEPTH));
  assign cell_ready = grant & {ROWS{~full & ~newboard}};
  assign push       = |cell_ready;
  assign pop        = m_valid & m_ready & ~newboard;
  assign win_move   = cell_move[18*int'(win) +: 18];

  always_ff @(posedge clk) begin
    if (push) mem[wr] <= {win_move, score[win]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr       <= '0;
      rd       <= '0;
      level    <= '0;
      rr       <= '0;
      col_done <= 1'b0;
    end else if (newboard) begin
      wr       <= '0;
      rd       <= '0;
      level    <= '0;
      rr       <= '0;
      col_done <= 1'b0;
    end else begin
      if (push) begin
        wr <= wr + AW'(1);
        rr <= (int'(win) == ROWS-1) ? '0 : win + RW'(1);
      end
      if (pop) rd <= rd + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
      if (&cell_done && !(|cell_valid) && level == '0) col_done <= 1'b1;
    end
  end

  // Gating with m_valid keeps the head outputs at zero after reset and flush,
  // since the storage array itself is not cleared.
  assign m_valid = (level != '0);
  assign head    = mem[rd];
  assign m_move  = m_valid ? head[23:6] : '0;
  assign m_score = m_valid ? head[5:0]  : '0;

endmodule

// File: tb/tb_column_move_collector.sv
// tb_column_move_collector: directed bench for column_move_collector.
// One MVV-LVA instance (u_dut) and one round-robin instance (u_rr) share the
// stimulus; only the instance relevant to each phase is checked.
module tb_column_move_collector;

  localparam int ROWS  = 8;
  localparam int DEPTH = 16;

  logic              clk;
  logic              rst;
  logic              newboard;
  logic [ROWS-1:0]   cell_valid;
  logic [ROWS*18-1:0] cell_move;
  logic [ROWS-1:0]   cell_done;
  logic [ROWS-1:0]   cell_ready;
  logic              m_valid;
  logic [17:0]       m_move;
  logic [5:0]        m_score;
  logic              m_ready;
  logic [4:0]        level;
  logic              col_done;

  logic [ROWS-1:0]   rr_ready;
  logic              rr_valid;
  logic [17:0]       rr_move;
  logic [5:0]        rr_score;
  logic [4:0]        rr_level;
  logic              rr_done;

  int checks = 0;
  int errors = 0;

  column_move_collector #(.ROWS(ROWS), .DEPTH(DEPTH), .SORT(1)) u_dut (
    .clk(clk), .rst(rst), .newboard(newboard),
    .cell_valid(cell_valid), .cell_move(cell_move), .cell_done(cell_done),
    .cell_ready(cell_ready), .m_valid(m_valid), .m_move(m_move),
    .m_score(m_score), .m_ready(m_ready), .level(level), .col_done(col_done)
  );

  column_move_collector #(.ROWS(ROWS), .DEPTH(DEPTH), .SORT(0)) u_rr (
    .clk(clk), .rst(rst), .newboard(newboard),
    .cell_valid(cell_valid), .cell_move(cell_move), .cell_done(cell_done),
    .cell_ready(rr_ready), .m_valid(rr_valid), .m_move(rr_move),
    .m_score(rr_score), .m_ready(m_ready), .level(rr_level), .col_done(rr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int r, input logic v, input logic [17:0] m);
    cell_valid[r]        = v;
    cell_move[18*r +: 18] = m;
  endtask

  function automatic logic [17:0] mk(input logic [11:0] coords, input logic [2:0] att,
                                     input logic [2:0] vic);
    return {coords, att, vic};
  endfunction

  // Sequence moves: quiet pawn moves tagged with k in the coordinate field.
  function automatic logic [17:0] mv(input int k);
    return mk(12'(k), 3'd1, 3'd0);
  endfunction

  initial begin
    rst = 1'b0; newboard = 1'b0; cell_valid = '0; cell_move = '0;
    cell_done = '0; m_ready = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("rst_level", level, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_col_done", col_done, 0);
    check("rst_m_move", m_move, 0);
    check("rst_m_score", m_score, 0);
    tick(); tick();
    rst = 1'b0;

    // MVV-LVA: pawn x queen (o56), queen x pawn (o12), quiet knight (o05)
    set_row(2, 1'b1, mk(12'o1234, 3'd1, 3'd5));
    set_row(5, 1'b1, mk(12'o2345, 3'd5, 3'd1));
    set_row(0, 1'b1, mk(12'o3456, 3'd2, 3'd0));
    #1 check("mvv_grant0", cell_ready, 8'b00000100);
    tick();
    check("mvv_head_score", m_score, 6'o56);
    check("mvv_head_move", m_move, mk(12'o1234, 3'd1, 3'd5));
    set_row(2, 1'b0, '0);
    #1 check("mvv_grant1", cell_ready, 8'b00100000);
    tick();
    set_row(5, 1'b0, '0);
    #1 check("mvv_grant2", cell_ready, 8'b00000001);
    tick();
    set_row(0, 1'b0, '0);
    m_ready = 1'b1;
    #1 check("mvv_level3", level, 3);
    check("mvv_pop0", m_score, 6'o56);
    tick();
    check("mvv_pop1", m_score, 6'o12);
    tick();
    check("mvv_pop2", m_score, 6'o05);
    tick();
    m_ready = 1'b0;
    check("mvv_empty", m_valid, 0);

    // Tie: rook x rook on rows 1 and 6 (o43)
    set_row(1, 1'b1, mk(12'o0101, 3'd4, 3'd4));
    set_row(6, 1'b1, mk(12'o0606, 3'd4, 3'd4));
    #1 check("tie_grant0", cell_ready, 8'b00000010);
    tick();
    set_row(1, 1'b0, '0);
    #1 check("tie_grant1", cell_ready, 8'b01000000);
    tick();
    set_row(6, 1'b0, '0);
    m_ready = 1'b1;
    #1 check("tie_level", level, 2);
    check("tie_score", m_score, 6'o43);
    check("tie_first", m_move, mk(12'o0101, 3'd4, 3'd4));
    tick();
    check("tie_second", m_move, mk(12'o0606, 3'd4, 3'd4));
    tick();
    m_ready = 1'b0;
    check("tie_empty", m_valid, 0);

    // Full: fill 16, blocked even with m_ready, resume after one pop, drain across wrap
    for (int k = 0; k < DEPTH; k++) begin
      set_row(3, 1'b1, mv(k));
      #1 check("fill_grant", cell_ready, 8'h08);
      tick();
    end
    set_row(3, 1'b1, mv(16));
    #1 check("full_level", level, 16);
    check("full_block", cell_ready, 0);
    m_ready = 1'b1;
    #1 check("full_block_pop", cell_ready, 0);
    check("full_head", m_move, mv(0));
    tick();
    m_ready = 1'b0;
    #1 check("full_level15", level, 15);
    check("full_resume", cell_ready, 8'h08);
    tick();
    set_row(3, 1'b0, '0);
    #1 check("full_refill", level, 16);
    check("full_block2", cell_ready, 0);
    m_ready = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      #1 check("drain_order", m_move, mv(k));
      tick();
    end
    m_ready = 1'b0;
    check("drain_empty", m_valid, 0);

    // Flush with level 3 and m_ready high
    for (int k = 0; k < 3; k++) begin
      set_row(0, 1'b1, mv(100 + k));
      tick();
    end
    set_row(0, 1'b1, mv(200));
    m_ready  = 1'b1;
    newboard = 1'b1;
    #1 check("flush_level3", level, 3);
    check("flush_block", cell_ready, 0);
    tick();
    newboard = 1'b0;
    m_ready  = 1'b0;
    set_row(0, 1'b0, '0);
    #1 check("flush_level0", level, 0);
    check("flush_m_valid", m_valid, 0);

    // Column done: set one edge later, sticky until newboard
    cell_done = '1;
    #1 check("done_pre", col_done, 0);
    tick();
    check("done_set", col_done, 1);
    cell_done = '0;
    tick();
    check("done_hold", col_done, 1);
    newboard = 1'b1;
    tick();
    newboard = 1'b0;
    #1 check("done_clr", col_done, 0);

    // Round-robin instance: all rows valid continuously
    m_ready = 1'b1;
    for (int r = 0; r < ROWS; r++) set_row(r, 1'b1, mv(400 + r));
    for (int i = 0; i <= ROWS; i++) begin
      #1 check("rr_grant", rr_ready, 32'(1) << (i % ROWS));
      tick();
    end
    cell_valid = '0;
    tick(); tick();
    m_ready = 1'b0;

    // Reset mid-stream with level 5, then first accept goes to the winner
    newboard = 1'b1;
    tick();
    newboard = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_row(4, 1'b1, mv(300 + k));
      tick();
    end
    set_row(4, 1'b0, '0);
    #1 check("mid_level5", level, 5);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_level", level, 0);
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_col_done", col_done, 0);
    #1 rst = 1'b0;
    set_row(3, 1'b1, mk(12'o3333, 3'd1, 3'd5));
    set_row(7, 1'b1, mk(12'o7777, 3'd5, 3'd1));
    #1 check("post_rst_grant", cell_ready, 8'h08);
    tick();
    cell_valid = '0;
    check("post_rst_move", m_move, mk(12'o3333, 3'd1, 3'd5));
    check("post_rst_level", level, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
